// File: rtl/mc_control_pkg.sv
// Shared constants for the multicycle MIPS control path: state encodings,
// opcode/funct values and ALU operation codes.
package mc_control_pkg;

   localparam logic [3:0] S_FETCH  = 4'd0;
   localparam logic [3:0] S_DECODE = 4'd1;
   localparam logic [3:0] S_MEMADR = 4'd2;
   localparam logic [3:0] S_MEMRD  = 4'd3;
   localparam logic [3:0] S_MEMWB  = 4'd4;
   localparam logic [3:0] S_MEMWR  = 4'd5;
   localparam logic [3:0] S_EXEC   = 4'd6;
   localparam logic [3:0] S_RWB    = 4'd7;
   localparam logic [3:0] S_BRANCH = 4'd8;
   localparam logic [3:0] S_IEXEC  = 4'd9;
   localparam logic [3:0] S_IWB    = 4'd10;
   localparam logic [3:0] S_JUMP   = 4'd11;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] F_ADD = 6'b100000;
   localparam logic [5:0] F_SUB = 6'b100010;
   localparam logic [5:0] F_AND = 6'b100100;
   localparam logic [5:0] F_OR  = 6'b100101;
   localparam logic [5:0] F_SLT = 6'b101010;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

   function automatic logic opcode_legal(input logic [5:0] op);
      case (op)
         OP_RTYPE, OP_LW, OP_SW, OP_BEQ,
         OP_ADDI, OP_ANDI, OP_ORI, OP_J: opcode_legal = 1'b1;
         default:                         opcode_legal = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/mc_control_alu_decode.sv
// Combinational ALU control: maps (state, opcode, funct) to the ALU op code,
// immediate extension mode and an unsupported-funct flag.
module alu_decode
   import mc_control_pkg::*;
(
   input  logic [3:0] state_i,
   input  logic [5:0] opcode_i,
   input  logic [5:0] funct_i,
   output logic [2:0] alu_op_o,
   output logic       zero_ext_o,
   output logic       funct_illegal_o
);

   always_comb begin
      alu_op_o        = ALU_ADD;
      zero_ext_o      = 1'b0;
      funct_illegal_o = 1'b0;
      case (state_i)
         S_EXEC: begin
            case (funct_i)
               F_ADD:   alu_op_o = ALU_ADD;
               F_SUB:   alu_op_o = ALU_SUB;
               F_AND:   alu_op_o = ALU_AND;
               F_OR:    alu_op_o = ALU_OR;
               F_SLT:   alu_op_o = ALU_SLT;
               default: funct_illegal_o = 1'b1;
            endcase
         end
         S_BRANCH: alu_op_o = ALU_SUB;
         S_IEXEC: begin
            case (opcode_i)
               OP_ANDI: begin
                  alu_op_o   = ALU_AND;
                  zero_ext_o = 1'b1;
               end
               OP_ORI: begin
                  alu_op_o   = ALU_OR;
                  zero_ext_o = 1'b1;
               end
               default: alu_op_o = ALU_ADD;
            endcase
         end
         // Extension mode must persist into writeback with the immediate result.
         S_IWB: zero_ext_o = (opcode_i == OP_ANDI) || (opcode_i == OP_ORI);
         default: ;
      endcase
   end

endmodule

// File: rtl/mc_control.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback
// over a shared datapath and counts retired instructions.
module mc_control
   import mc_control_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [5:0]       opcode,
   input  logic [5:0]       funct,
   input  logic             zero,
   input  logic             memReady,
   output logic             pcEn,
   output logic             iorD,
   output logic             memRead,
   output logic             memWrite,
   output logic             irWrite,
   output logic             regDst,
   output logic             memToReg,
   output logic             regWrite,
   output logic             aluSrcA,
   output logic [1:0]       aluSrcB,
   output logic [2:0]       aluOp,
   output logic [1:0]       pcSrc,
   output logic             zeroExt,
   output logic             illegalOp,
   output logic [3:0]       state,
   output logic [CNT_W-1:0] instrCount
);

   logic [3:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             retire;
   logic             funct_illegal;
   logic             pc_write, branch, mem_rd, mem_wr, ir_wr, reg_wr, op_illegal;

   alu_decode u_alu_decode (
      .state_i         (state_q),
      .opcode_i        (opcode),
      .funct_i         (funct),
      .alu_op_o        (aluOp),
      .zero_ext_o      (zeroExt),
      .funct_illegal_o (funct_illegal)
   );

   always_comb begin
      state_d = S_FETCH;
      retire  = 1'b0;
      case (state_q)
         S_FETCH:  state_d = memReady ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (opcode)
               OP_RTYPE:               state_d = S_EXEC;
               OP_LW, OP_SW:           state_d = S_MEMADR;
               OP_BEQ:                 state_d = S_BRANCH;
               OP_ADDI, OP_ANDI, OP_ORI: state_d = S_IEXEC;
               OP_J:                   state_d = S_JUMP;
               default:                state_d = S_FETCH;
            endcase
         end
         S_MEMADR: state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
         S_MEMRD:  state_d = memReady ? S_MEMWB : S_MEMRD;
         S_MEMWB:  retire  = 1'b1;
         S_MEMWR: begin
            state_d = memReady ? S_FETCH : S_MEMWR;
            retire  = memReady;
         end
         S_EXEC:   state_d = funct_illegal ? S_FETCH : S_RWB;
         S_RWB:    retire  = 1'b1;
         S_BRANCH: retire  = 1'b1;
         S_IEXEC:  state_d = S_IWB;
         S_IWB:    retire  = 1'b1;
         S_JUMP:   retire  = 1'b1;
         default:  state_d = S_FETCH;
      endcase
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, retire};
   end

   always_comb begin
      pc_write   = 1'b0;
      branch     = 1'b0;
      mem_rd     = 1'b0;
      mem_wr     = 1'b0;
      ir_wr      = 1'b0;
      reg_wr     = 1'b0;
      op_illegal = 1'b0;
      iorD       = 1'b0;
      regDst     = 1'b0;
      memToReg   = 1'b0;
      aluSrcA    = 1'b0;
      aluSrcB    = 2'b00;
      pcSrc      = 2'b00;
      case (state_q)
         S_FETCH: begin
            mem_rd   = 1'b1;
            aluSrcB  = 2'b01;
            ir_wr    = memReady;
            pc_write = memReady;
         end
         S_DECODE: begin
            aluSrcB    = 2'b11;
            op_illegal = !opcode_legal(opcode);
         end
         S_MEMADR: begin
            aluSrcA = 1'b1;
            aluSrcB = 2'b10;
         end
         S_MEMRD: begin
            mem_rd = 1'b1;
            iorD   = 1'b1;
         end
         S_MEMWB: begin
            reg_wr   = 1'b1;
            memToReg = 1'b1;
         end
         S_MEMWR: begin
            mem_wr = 1'b1;
            iorD   = 1'b1;
         end
         S_EXEC:   aluSrcA = 1'b1;
         S_RWB: begin
            reg_wr = 1'b1;
            regDst = 1'b1;
         end
         S_BRANCH: begin
            aluSrcA = 1'b1;
            pcSrc   = 2'b01;
            branch  = 1'b1;
         end
         S_IEXEC: begin
            aluSrcA = 1'b1;
            aluSrcB = 2'b10;
         end
         S_IWB:    reg_wr = 1'b1;
         S_JUMP: begin
            pcSrc    = 2'b10;
            pc_write = 1'b1;
         end
         default: ;
      endcase
   end

   // Strobes are qualified by rst_n so nothing writes while reset is held.
   assign pcEn       = rst_n & (pc_write | (branch & zero));
   assign memRead    = rst_n & mem_rd;
   assign memWrite   = rst_n & mem_wr;
   assign irWrite    = rst_n & ir_wr;
   assign regWrite   = rst_n & reg_wr;
   assign illegalOp  = rst_n & (op_illegal | funct_illegal);
   assign state      = state_q;
   assign instrCount = cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_FETCH;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_mc_control.sv
// Self-checking bench for mc_control: per-instruction state paths and control
// words predicted from the instruction-level behaviour, with random stalls.
module tb_mc_control;

   localparam logic [3:0] FETCH = 0, DECODE = 1, MEMADR = 2, MEMRD = 3, MEMWB = 4,
                          MEMWR = 5, EXEC = 6, RWB = 7, BRANCH = 8, IEXEC = 9,
                          IWB = 10, JUMP = 11;

   typedef struct packed {
      logic       pcEn, iorD, memRead, memWrite, irWrite, regDst, memToReg, regWrite, aluSrcA;
      logic [1:0] aluSrcB;
      logic [2:0] aluOp;
      logic [1:0] pcSrc;
      logic       zeroExt, illegalOp;
   } ctrl_t;

   logic        clk, rst_n, zero, memReady;
   logic [5:0]  opcode, funct;
   logic        pcEn, iorD, memRead, memWrite, irWrite, regDst, memToReg, regWrite, aluSrcA;
   logic [1:0]  aluSrcB, pcSrc;
   logic [2:0]  aluOp;
   logic        zeroExt, illegalOp;
   logic [3:0]  state;
   logic [31:0] instrCount;

   int          checks = 0;
   int          failures = 0;
   logic [31:0] model_cnt = 0;

   mc_control #(.CNT_W(32)) dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
      .memReady(memReady), .pcEn(pcEn), .iorD(iorD), .memRead(memRead),
      .memWrite(memWrite), .irWrite(irWrite), .regDst(regDst), .memToReg(memToReg),
      .regWrite(regWrite), .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .aluOp(aluOp),
      .pcSrc(pcSrc), .zeroExt(zeroExt), .illegalOp(illegalOp), .state(state),
      .instrCount(instrCount)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Instruction classes from the ISA subset the core supports.
   function automatic bit op_ok(input logic [5:0] op);
      return op == 6'b000000 || op == 6'b100011 || op == 6'b101011 || op == 6'b000100 ||
             op == 6'b001000 || op == 6'b001100 || op == 6'b001101 || op == 6'b000010;
   endfunction

   // Returns {legal, aluOp} for an R-type funct field.
   function automatic logic [3:0] fmap(input logic [5:0] fn);
      case (fn)
         6'b100000: return {1'b1, 3'b010};
         6'b100010: return {1'b1, 3'b110};
         6'b100100: return {1'b1, 3'b000};
         6'b100101: return {1'b1, 3'b001};
         6'b101010: return {1'b1, 3'b111};
         default:   return {1'b0, 3'b010};
      endcase
   endfunction

   function automatic ctrl_t exp_ctrl(input logic [3:0] st, input logic [5:0] op,
                                      input logic [5:0] fn, input logic zr, input logic rdy);
      ctrl_t c;
      logic [3:0] fm;
      c = '0;
      c.aluOp = 3'b010;
      fm = fmap(fn);
      case (st)
         FETCH:  begin c.memRead = 1; c.aluSrcB = 2'b01; c.irWrite = rdy; c.pcEn = rdy; end
         DECODE: begin c.aluSrcB = 2'b11; c.illegalOp = !op_ok(op); end
         MEMADR: begin c.aluSrcA = 1; c.aluSrcB = 2'b10; end
         MEMRD:  begin c.memRead = 1; c.iorD = 1; end
         MEMWB:  begin c.regWrite = 1; c.memToReg = 1; end
         MEMWR:  begin c.memWrite = 1; c.iorD = 1; end
         EXEC:   begin c.aluSrcA = 1; c.aluOp = fm[2:0]; c.illegalOp = !fm[3]; end
         RWB:    begin c.regWrite = 1; c.regDst = 1; end
         BRANCH: begin c.aluSrcA = 1; c.aluOp = 3'b110; c.pcSrc = 2'b01; c.pcEn = zr; end
         IEXEC: begin
            c.aluSrcA = 1; c.aluSrcB = 2'b10;
            c.aluOp   = (op == 6'b001100) ? 3'b000 : (op == 6'b001101) ? 3'b001 : 3'b010;
            c.zeroExt = (op != 6'b001000);
         end
         IWB:    begin c.regWrite = 1; c.zeroExt = (op != 6'b001000); end
         JUMP:   begin c.pcSrc = 2'b10; c.pcEn = 1; end
         default: ;
      endcase
      return c;
   endfunction

   function automatic ctrl_t got_ctrl();
      return {pcEn, iorD, memRead, memWrite, irWrite, regDst, memToReg, regWrite, aluSrcA,
              aluSrcB, aluOp, pcSrc, zeroExt, illegalOp};
   endfunction

   task automatic run_instr(input string tag, input logic [5:0] op, input logic [5:0] fn,
                            input logic zr, input int fst, input int mst);
      logic [3:0] sq[$];
      logic       rq[$];
      bit         ret;
      ctrl_t      e, g;
      ret = 0;
      for (int i = 0; i < fst; i++) begin sq.push_back(FETCH); rq.push_back(0); end
      sq.push_back(FETCH);  rq.push_back(1);
      sq.push_back(DECODE); rq.push_back(1'($urandom_range(0, 1)));
      if (op == 6'b000000) begin
         sq.push_back(EXEC); rq.push_back(1'($urandom_range(0, 1)));
         if (fmap(fn) >= 4'h8) begin sq.push_back(RWB); rq.push_back(1'($urandom_range(0, 1))); ret = 1; end
      end else if (op == 6'b100011 || op == 6'b101011) begin
         sq.push_back(MEMADR); rq.push_back(1'($urandom_range(0, 1)));
         for (int i = 0; i < mst; i++) begin
            sq.push_back(op == 6'b100011 ? MEMRD : MEMWR); rq.push_back(0);
         end
         sq.push_back(op == 6'b100011 ? MEMRD : MEMWR); rq.push_back(1);
         if (op == 6'b100011) begin sq.push_back(MEMWB); rq.push_back(1'($urandom_range(0, 1))); end
         ret = 1;
      end else if (op == 6'b000100) begin
         sq.push_back(BRANCH); rq.push_back(1'($urandom_range(0, 1))); ret = 1;
      end else if (op == 6'b000010) begin
         sq.push_back(JUMP); rq.push_back(1'($urandom_range(0, 1))); ret = 1;
      end else if (op_ok(op)) begin
         sq.push_back(IEXEC); rq.push_back(1'($urandom_range(0, 1)));
         sq.push_back(IWB);   rq.push_back(1'($urandom_range(0, 1)));
         ret = 1;
      end
      foreach (sq[i]) begin
         @(negedge clk);
         opcode = op; funct = fn; zero = zr; memReady = rq[i];
         #1;
         e = exp_ctrl(sq[i], op, fn, zr, rq[i]);
         g = got_ctrl();
         checks++;
         if (state !== sq[i]) begin
            failures++;
            $display("FAIL %s state cyc%0d: got %0d want %0d", tag, i, state, sq[i]);
         end
         checks++;
         if (g !== e) begin
            failures++;
            $display("FAIL %s ctrl cyc%0d st%0d: got %h want %h", tag, i, sq[i], g, e);
         end
      end
      if (ret) model_cnt++;
      @(negedge clk);
      memReady = 0;
      #1;
      checks++;
      if (state !== FETCH) begin
         failures++;
         $display("FAIL %s return state: got %0d want 0", tag, state);
      end
      checks++;
      if (instrCount !== model_cnt) begin
         failures++;
         $display("FAIL %s instrCount: got %0d want %0d", tag, instrCount, model_cnt);
      end
   endtask

   task automatic test_reset();
      rst_n = 0; memReady = 1; zero = 1; opcode = 0; funct = 6'b100000;
      #1;
      checks++;
      if (state !== FETCH || instrCount !== 0) begin
         failures++;
         $display("FAIL reset state/count: got %0d/%0d want 0/0", state, instrCount);
      end
      checks++;
      if ({pcEn, irWrite, regWrite, memRead, memWrite, illegalOp} !== 6'b0) begin
         failures++;
         $display("FAIL reset strobes: got %b want 000000",
                  {pcEn, irWrite, regWrite, memRead, memWrite, illegalOp});
      end
      repeat (2) @(negedge clk);
      memReady = 0;
      rst_n = 1;
      model_cnt = 0;
   endtask

   task automatic test_rtype_add();
      run_instr("add", 6'b000000, 6'b100000, 0, 0, 0);
   endtask

   task automatic test_lw_stall();
      run_instr("lw_stall", 6'b100011, 6'd0, 0, 0, 3);
   endtask

   task automatic test_beq();
      run_instr("beq_taken", 6'b000100, 6'd0, 1, 0, 0);
      run_instr("beq_not", 6'b000100, 6'd0, 0, 0, 0);
   endtask

   task automatic test_imm();
      run_instr("andi", 6'b001100, 6'd0, 0, 0, 0);
      run_instr("ori", 6'b001101, 6'd0, 0, 1, 0);
      run_instr("addi", 6'b001000, 6'd0, 1, 0, 0);
      run_instr("j", 6'b000010, 6'd0, 0, 0, 0);
   endtask

   task automatic test_illegal();
      run_instr("bad_op", 6'b111111, 6'd0, 0, 0, 0);
      run_instr("bad_funct", 6'b000000, 6'b000111, 0, 0, 0);
   endtask

   task automatic test_sw_reset();
      logic [3:0] path [4] = '{FETCH, DECODE, MEMADR, MEMWR};
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         opcode = 6'b101011; memReady = (i == 0); zero = 0;
         #1;
         checks++;
         if (state !== path[i]) begin
            failures++;
            $display("FAIL sw_rst path cyc%0d: got %0d want %0d", i, state, path[i]);
         end
      end
      checks++;
      if (memWrite !== 1'b1) begin
         failures++;
         $display("FAIL sw_rst memWrite before reset: got %b want 1", memWrite);
      end
      #1 rst_n = 0;
      #1;
      checks++;
      if ({memWrite, regWrite, pcEn} !== 3'b000 || state !== FETCH || instrCount !== 0) begin
         failures++;
         $display("FAIL sw_rst async: strobes %b st %0d cnt %0d want 000 0 0",
                  {memWrite, regWrite, pcEn}, state, instrCount);
      end
      model_cnt = 0;
      @(negedge clk);
      rst_n = 1;
      #1;
      checks++;
      if (state !== FETCH || memRead !== 1'b1) begin
         failures++;
         $display("FAIL sw_rst resume: st %0d memRead %b want 0 1", state, memRead);
      end
      run_instr("after_rst", 6'b000000, 6'b100010, 0, 0, 0);
   endtask

   task automatic test_random();
      logic [5:0] ops [8] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100,
                              6'b001000, 6'b001100, 6'b001101, 6'b000010};
      logic [5:0] fns [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
      logic [5:0] op, fn;
      for (int n = 0; n < 40; n++) begin
         op = ops[$urandom_range(0, 7)];
         if ($urandom_range(0, 9) == 0) begin
            do op = 6'($urandom); while (op_ok(op));
         end
         fn = ($urandom_range(0, 7) == 0) ? 6'($urandom) : fns[$urandom_range(0, 4)];
         run_instr("random", op, fn, 1'($urandom_range(0, 1)),
                   $urandom_range(0, 3), $urandom_range(0, 3));
      end
   endtask

   initial begin
      test_reset();
      test_rtype_add();
      test_lw_stall();
      test_beq();
      test_imm();
      test_illegal();
      test_sw_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
